bus_rr_arbiter: RTL

Round-robin arbiter and transfer watchdog for the four-master shared system bus. It owns the grant lines and the owner-select index that steer the master-side address/data mux. It also tracks each granted transfer from address strobe to slave ready. If a slave never answers, it aborts the transfer with a synthetic ready and an error pulse, so a missing or dead slave cannot hang the CPU.

---
 rtl/bus_rr_arbiter_pkg.sv | 22 ++
 rtl/bus_rr_pick.sv | 35 +++
 rtl/bus_rr_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_arbiter_pkg
// Description : Shared constants for the four-master system bus arbiter:
//               FSM state encodings, master count, owner index width and
//               the default transfer watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_rr_arbiter_pkg;

   localparam int BUS_MASTER_CH = 4;
   localparam int BUS_OWNER_W   = 2;
   localparam int BUS_TIMEOUT   = 255;
   localparam int BUS_CNT_W     = 8;

   localparam logic [1:0] BUS_ARB_IDLE  = 2'd0;
   localparam logic [1:0] BUS_ARB_OWNED = 2'd1;
   localparam logic [1:0] BUS_ARB_XFER  = 2'd2;
   localparam logic [1:0] BUS_ARB_ABORT = 2'd3;

endpackage : bus_rr_arbiter_pkg
`default_nettype wire

// File: rtl/bus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_pick
// Description : Combinational round-robin selector. Returns the first
//               requester found searching ptr, ptr+1, ... (mod 4).
// Ports       : req     - request vector, active-high
//               ptr     - index where the search starts
//               winner  - index of the selected requester
//               any_req - high when at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_pick
   import bus_rr_arbiter_pkg::*;
(
   input  logic [BUS_MASTER_CH-1:0] req,
   input  logic [BUS_OWNER_W-1:0]   ptr,
   output logic [BUS_OWNER_W-1:0]   winner,
   output logic                     any_req
);

   // Walk the offsets from farthest to nearest so the nearest requester
   // (lowest offset from ptr) is the last assignment and therefore wins.
   // The 2-bit addition wraps 3 -> 0 naturally.
   always_comb begin
      winner  = ptr;
      any_req = |req;
      for (int i = BUS_MASTER_CH - 1; i >= 0; i--) begin
         if (req[ptr + BUS_OWNER_W'(i)]) begin
            winner = ptr + BUS_OWNER_W'(i);
         end
      end
   end

endmodule : bus_rr_pick
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_arbiter
// Description : Round-robin arbiter and transfer watchdog for the four-master
//               shared bus. Grants one master at a time, tracks each transfer
//               from address strobe to slave ready and aborts it with a
//               synthetic ready plus an error pulse when the slave is silent
//               for TIMEOUT cycles.
// Ports       : clk, reset (async, active-high)
//               mReq_[3:0]  per-master request, active-low
//               mAs_[3:0]   per-master address strobe, active-low
//               sRdy_       shared slave ready, active-low
//               mGrnt_[3:0] per-master grant, active-low, one-hot-low
//               owner[1:0]  granted master index (mux select)
//               ownerVld    a grant is held
//               forceRdy_   synthetic ready on abort, active-low pulse
//               busErr      one-cycle pulse on abort
//               errMaster   owner index at the last abort
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter
   import bus_rr_arbiter_pkg::*;
#(
   parameter int TIMEOUT = BUS_TIMEOUT
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BUS_MASTER_CH-1:0] mReq_,
   input  logic [BUS_MASTER_CH-1:0] mAs_,
   input  logic                     sRdy_,
   output logic [BUS_MASTER_CH-1:0] mGrnt_,
   output logic [BUS_OWNER_W-1:0]   owner,
   output logic                     ownerVld,
   output logic                     forceRdy_,
   output logic                     busErr,
   output logic [BUS_OWNER_W-1:0]   errMaster
);

   localparam logic [BUS_CNT_W-1:0] C_CNT_LAST = BUS_CNT_W'(TIMEOUT - 1);

   logic [1:0]               state_q, state_d;
   logic [BUS_OWNER_W-1:0]   ptr_q, ptr_d;
   logic [BUS_CNT_W-1:0]     cnt_q, cnt_d;
   logic [BUS_MASTER_CH-1:0] mgrnt_q, mgrnt_d;
   logic [BUS_OWNER_W-1:0]   owner_q, owner_d;
   logic                     owner_vld_q, owner_vld_d;
   logic                     force_rdy_q, force_rdy_d;
   logic                     bus_err_q, bus_err_d;
   logic [BUS_OWNER_W-1:0]   err_master_q, err_master_d;

   logic [BUS_OWNER_W-1:0]   w_winner;
   logic                     w_any_req;
   logic                     w_owner_as;
   logic                     w_owner_rel;
   logic                     w_rdy;
   logic                     w_cnt_last;

   assign w_owner_as  = ~mAs_[owner_q];
   assign w_owner_rel = mReq_[owner_q];
   assign w_rdy       = ~sRdy_;
   assign w_cnt_last  = (cnt_q == C_CNT_LAST);

   bus_rr_pick u_pick (
      .req     (~mReq_),
      .ptr     (ptr_q),
      .winner  (w_winner),
      .any_req (w_any_req)
   );

   // State register and all output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= BUS_ARB_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         mgrnt_q      <= '1;
         owner_q      <= '0;
         owner_vld_q  <= 1'b0;
         force_rdy_q  <= 1'b1;
         bus_err_q    <= 1'b0;
         err_master_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         mgrnt_q      <= mgrnt_d;
         owner_q      <= owner_d;
         owner_vld_q  <= owner_vld_d;
         force_rdy_q  <= force_rdy_d;
         bus_err_q    <= bus_err_d;
         err_master_q <= err_master_d;
      end
   end

   // Next-state logic. Release is honoured only in OWNED, so a master that
   // drops its request mid-transfer keeps the bus until the transfer ends.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         BUS_ARB_IDLE: begin
            if (w_any_req) state_d = BUS_ARB_OWNED;
         end
         BUS_ARB_OWNED: begin
            if (w_owner_as) begin
               state_d = BUS_ARB_XFER;
               cnt_d   = '0;
            end else if (w_owner_rel) begin
               state_d = BUS_ARB_IDLE;
               ptr_d   = owner_q + 1'b1;
            end
         end
         BUS_ARB_XFER: begin
            // Ready has priority over the last watchdog count.
            if (w_rdy) begin
               state_d = BUS_ARB_OWNED;
            end else if (w_cnt_last) begin
               state_d = BUS_ARB_ABORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BUS_ARB_ABORT: begin
            state_d = BUS_ARB_OWNED;
         end
         default: begin
            state_d = BUS_ARB_IDLE;
         end
      endcase
   end

   // Output logic: next values of the registered outputs, keyed on the
   // transition being taken so every output changes on the same edge as
   // the state.
   always_comb begin
      mgrnt_d      = mgrnt_q;
      owner_d      = owner_q;
      owner_vld_d  = owner_vld_q;
      force_rdy_d  = 1'b1;
      bus_err_d    = 1'b0;
      err_master_d = err_master_q;
      if (state_q == BUS_ARB_IDLE && state_d == BUS_ARB_OWNED) begin
         mgrnt_d     = ~(BUS_MASTER_CH'(1) << w_winner);
         owner_d     = w_winner;
         owner_vld_d = 1'b1;
      end
      if (state_q == BUS_ARB_OWNED && state_d == BUS_ARB_IDLE) begin
         mgrnt_d     = '1;
         owner_vld_d = 1'b0;
      end
      if (state_d == BUS_ARB_ABORT) begin
         force_rdy_d  = 1'b0;
         bus_err_d    = 1'b1;
         err_master_d = owner_q;
      end
   end

   assign mGrnt_    = mgrnt_q;
   assign owner     = owner_q;
   assign ownerVld  = owner_vld_q;
   assign forceRdy_ = force_rdy_q;
   assign busErr    = bus_err_q;
   assign errMaster = err_master_q;

endmodule : bus_rr_arbiter
`default_nettype wire
